// File: rtl/ifetch_queue.sv
// Instruction fetch front-end: PC sequencer, 1-cycle synchronous imem interface,
// DEPTH-entry instruction/PC FIFO towards decode, and branch/jump redirect flush.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_OCC = (CW+1)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q;
  logic          inflight_q;
  logic          kill_q;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];

  logic          push;
  logic          pop;
  logic [CW:0]   occupancy;

  assign imem_addr = pc_q;
  assign out_instr = instr_mem_q[head_q];
  assign out_pc    = pc_mem_q[head_q];

  always_comb begin
    occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    // Credit counts outstanding requests but never a same-cycle pop.
    imem_req  = !rst && !redirect_valid && (occupancy < DEPTH_OCC);
    out_valid = (count_q != '0) && !redirect_valid;
    pop       = out_valid && out_ready;
    push      = inflight_q && !kill_q && !redirect_valid;

    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (imem_req) pc_d = pc_q + 32'd4;
      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= pc_q;
      inflight_q <= imem_req;
      kill_q     <= redirect_valid;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      if (push) begin
        instr_mem_q[tail_q] <= imem_rdata;
        pc_mem_q[tail_q]    <= req_pc_q;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: issued PCs are queued with their issue cycle
// and compared against the FIFO head as decode consumes it.
module tb_ifetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int nreq     = 0;

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } ent_t;
  ent_t        sb[$];
  logic [31:0] exp_pc = RESET_PC;

  ifetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    imem_rdata <= imem_addr ^ 32'hA5A5_0000;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: outstanding = scoreboard entries (in flight or buffered).
  always @(negedge clk) begin
    logic req_exp, ov_exp;
    ent_t e;
    if (rst) begin
      check("req_in_rst", imem_req, 1'b0);
      sb.delete();
      exp_pc = RESET_PC;
    end else begin
      req_exp = !redirect_valid && (sb.size() < DEPTH);
      ov_exp  = !redirect_valid && (sb.size() != 0) && (cyc - sb[0].cyc >= 2);
      check("imem_req", imem_req, req_exp);
      check("out_valid", out_valid, ov_exp);
      if (redirect_valid) begin
        sb.delete();
        exp_pc = redirect_pc & ~32'd3;
      end else begin
        if (ov_exp && out_ready) begin
          e = sb.pop_front();
          check("out_pc", out_pc, e.pc);
          check("out_instr", out_instr, e.pc ^ 32'hA5A5_0000);
        end
        if (req_exp) begin
          check("imem_addr", imem_addr, exp_pc);
          sb.push_back('{pc: exp_pc, cyc: cyc});
          exp_pc = exp_pc + 32'd4;
          nreq++;
        end
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    redirect_valid = 1'b0;
    out_ready = rdy;
    step(2);
    rst = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    step(1);
    redirect_valid = 1'b0;
  endtask

  initial begin
    int n0;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b1;
    step(2);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_imem_addr", imem_addr, RESET_PC);
    rst = 1'b0;

    // Streaming from reset
    step(12);

    // Backpressure from empty: exactly DEPTH requests, then drain in order
    do_reset(1'b0);
    n0 = nreq;
    step(10);
    check("t2_reqs", nreq - n0, DEPTH);
    out_ready = 1'b1;
    step(8);

    // Mid-stream redirect with misaligned target
    step(3);
    redirect(32'h0000_0103);
    step(10);

    // Back-to-back redirects: last one wins
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    step(1);
    redirect_pc = 32'h0000_0300;
    step(1);
    redirect_valid = 1'b0;
    step(10);

    // Reset while stalled with FIFO filling and a request in flight
    out_ready = 1'b0;
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("t5_out_valid", out_valid, 1'b0);
    out_ready = 1'b1;
    step(8);

    // PC wrap
    redirect(32'hFFFF_FFF8);
    step(10);

    // Reset and redirect together: reset wins
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0800;
    step(1);
    rst = 1'b0;
    redirect_valid = 1'b0;
    check("rst_over_redir", imem_addr, RESET_PC);
    step(4);

    // Random backpressure and occasional redirects
    for (int i = 0; i < 200; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = $urandom;
      end else begin
        redirect_valid = 1'b0;
      end
      step(1);
    end
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    step(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
